// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares a single block-RAM port between two requesters:
//   m0 - core data port
//   m1 - loader / debug port
//
// Each requester has a valid/ready request channel and a valid/ready response
// channel. Arbitration is round-robin. One access can be issued per cycle as
// long as responses are consumed promptly. The BRAM is expected to have a
// 1-cycle registered, read-first dout. The response data is wired straight
// from mem_dout, so it has no extra register stage. While a response waits to
// be consumed, the port is not re-enabled, so dout (and therefore rdata)
// holds its value.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   mN_req_*         request channel of requester N (valid/ready/we/wstrb/
//                    addr/wdata)
//   mN_rsp_*         response channel of requester N (valid/ready/rdata);
//                    rdata is the pre-write word for writes
//   mem_*            BRAM port (en/we/wstrb/addr/din out, dout in)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic                    m0_req_we,
  input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  output logic                    m0_rsp_valid,
  input  logic                    m0_rsp_ready,
  output logic [DATA_WIDTH-1:0]   m0_rsp_rdata,

  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic                    m1_req_we,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  output logic                    m1_rsp_valid,
  input  logic                    m1_rsp_ready,
  output logic [DATA_WIDTH-1:0]   m1_rsp_rdata,

  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t st, st_next;
  logic   owner, owner_next;
  logic   last_grant, last_grant_next;

  logic   grant_valid;
  logic   grant;
  logic   rsp_done;
  logic   can_issue;
  logic   accept;

  logic                  sel_we;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin grant. Under contention, the requester that did not win last
  // time goes first. last_grant resets to 1, so the first contention after
  // reset goes to m0.
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    grant_valid = m0_req_valid || m1_req_valid;
    grant       = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      grant = ~last_grant;
    end else if (m1_req_valid) begin
      grant = 1'b1;
    end
  end

  // A new access may share the cycle in which the previous response is
  // consumed; this is what gives one access per cycle.
  assign rsp_done  = (st == BUSY) && (owner ? m1_rsp_ready : m0_rsp_ready);
  assign can_issue = (st == IDLE) || rsp_done;

  // rst also gates the combinational outputs. Otherwise the IDLE state that
  // reset forces would let ready/mem_en follow req_valid while reset is still
  // held.
  assign accept = can_issue && grant_valid && !rst;

  assign m0_req_ready = accept && (grant == 1'b0);
  assign m1_req_ready = accept && (grant == 1'b1);

  assign sel_we    = grant ? m1_req_we    : m0_req_we;
  assign sel_wstrb = grant ? m1_req_wstrb : m0_req_wstrb;
  assign sel_addr  = grant ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = grant ? m1_req_wdata : m0_req_wdata;

  // Reads drive zero strobes, so a stray strobe pattern on a read request can
  // never modify memory.
  assign mem_en    = accept;
  assign mem_we    = accept && sel_we;
  assign mem_wstrb = (accept && sel_we) ? sel_wstrb : '0;
  assign mem_addr  = sel_addr;
  assign mem_din   = sel_wdata;

  // Responses come straight from the BRAM output register. mem_en stays low
  // during a stall, so dout holds.
  assign m0_rsp_valid = (st == BUSY) && (owner == 1'b0);
  assign m1_rsp_valid = (st == BUSY) && (owner == 1'b1);
  assign m0_rsp_rdata = mem_dout;
  assign m1_rsp_rdata = mem_dout;

  always_comb begin
    st_next         = st;
    owner_next      = owner;
    last_grant_next = last_grant;
    if (accept) begin
      st_next         = BUSY;
      owner_next      = grant;
      last_grant_next = grant;
    end else if (rsp_done) begin
      st_next = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      st         <= st_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter with a behavioural read-first BRAM.
// The stimulus tasks push the expected response and its accept cycle into a
// per-requester queue. A monitor process pops from that queue on each response
// handshake and compares the read data and the 1-cycle latency.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  typedef struct {
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [3:0]  req_wstrb [2];
  logic [9:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready [2];

  wire         m0_req_ready, m1_req_ready;
  wire         m0_rsp_valid, m1_rsp_valid;
  wire  [31:0] m0_rsp_rdata, m1_rsp_rdata;
  wire         mem_en, mem_we;
  wire  [3:0]  mem_wstrb;
  wire  [9:0]  mem_addr;
  wire  [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  exp_t sb0 [$];
  exp_t sb1 [$];
  int   grant_log [$];
  int   acc_log   [$];
  logic started   [2];
  int   start_cyc [2];

  bram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_valid (req_valid[0]),
    .m0_req_ready (m0_req_ready),
    .m0_req_we    (req_we[0]),
    .m0_req_wstrb (req_wstrb[0]),
    .m0_req_addr  (req_addr[0]),
    .m0_req_wdata (req_wdata[0]),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (rsp_ready[0]),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m1_req_valid (req_valid[1]),
    .m1_req_ready (m1_req_ready),
    .m1_req_we    (req_we[1]),
    .m1_req_wstrb (req_wstrb[1]),
    .m1_req_addr  (req_addr[1]),
    .m1_req_wdata (req_wdata[1]),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (rsp_ready[1]),
    .m1_rsp_rdata (m1_rsp_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first BRAM with byte strobes and a registered output.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic ready_of(input int n);
    return (n == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  function automatic logic rsp_valid_of(input int n);
    return (n == 0) ? m0_rsp_valid : m1_rsp_valid;
  endfunction

  function automatic logic [31:0] rdata_of(input int n);
    return (n == 0) ? m0_rsp_rdata : m1_rsp_rdata;
  endfunction

  // Presents one request and holds it until accepted, then logs the expected
  // response. It returns just after the edge that follows acceptance.
  task automatic send(input int n, input logic we, input logic [3:0] strb,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata);
    int   budget;
    exp_t e;
    budget       = 0;
    req_valid[n] = 1'b1;
    req_we[n]    = we;
    req_wstrb[n] = strb;
    req_addr[n]  = addr;
    req_wdata[n] = wdata;
    forever begin
      @(negedge clk);
      if (ready_of(n)) break;
      budget++;
      if (budget > 100) break;
    end
    if (budget > 100) begin
      n_checks++;
      $display("FAIL accept_timeout m%0d: got no ready, expected ready within 100 cycles", n);
    end else begin
      e.rdata   = exp_rdata;
      e.acc_cyc = cyc;
      if (n == 0) sb0.push_back(e);
      else        sb1.push_back(e);
      grant_log.push_back(n);
      acc_log.push_back(cyc);
    end
    @(posedge clk);
    #1;
    req_valid[n] = 1'b0;
  endtask

  // Response monitor: the response data and the latency are compared on every
  // response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_rsp_valid || m1_rsp_valid)
        check("single_rsp_valid", {31'd0, m0_rsp_valid && m1_rsp_valid}, 32'd0);
      for (int n = 0; n < 2; n++) begin
        if (rsp_valid_of(n) && !started[n]) begin
          started[n]   = 1'b1;
          start_cyc[n] = cyc;
        end
        if (rsp_valid_of(n) && rsp_ready[n]) begin
          exp_t e;
          if ((n == 0 && sb0.size() == 0) || (n == 1 && sb1.size() == 0)) begin
            n_checks++;
            $display("FAIL unexpected_rsp m%0d: got rsp_valid, expected none pending", n);
          end else begin
            if (n == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("rsp_rdata m%0d", n), rdata_of(n), e.rdata);
            check($sformatf("rsp_latency m%0d", n), start_cyc[n], e.acc_cyc + 1);
          end
          started[n] = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h001] = 32'h1111_1111;
    mem[10'h002] = 32'h2222_2222;
    mem[10'h005] = 32'h5555_0005;
    mem[10'h010] = 32'h1122_3344;
    mem[10'h3FF] = 32'hCAFE_F00D;
    for (int i = 0; i < 8; i++) mem[10'h020 + i] = 32'hA000_0000 + i;

    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 1'b0;
      req_we[n]    = 1'b0;
      req_wstrb[n] = 4'h0;
      req_addr[n]  = '0;
      req_wdata[n] = '0;
      rsp_ready[n] = 1'b1;
      started[n]   = 1'b0;
      start_cyc[n] = 0;
    end

    // Reset state: outputs stay quiet even with a request pending.
    rst          = 1'b1;
    req_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("reset m0_req_ready", {31'd0, m0_req_ready}, 32'd0);
    check("reset mem_en", {31'd0, mem_en}, 32'd0);
    check("reset rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention straight after reset: grants must go 0,1,0,1..., one per cycle.
    grant_log.delete();
    acc_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 1'b0, 4'h0, 10'h001, 32'h0, 32'h1111_1111);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 1'b0, 4'h0, 10'h002, 32'h0, 32'h2222_2222);
      end
    join
    check("contention grant count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check($sformatf("contention grant[%0d]", i), grant_log[i], i % 2);
      if (i > 0) check($sformatf("contention cycle[%0d]", i), acc_log[i], acc_log[i-1] + 1);
    end

    // Full write, then read-after-write back-to-back on m0.
    send(0, 1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF, 32'h5555_0005);
    send(0, 1'b0, 4'h0, 10'h005, 32'h0, 32'hDEAD_BEEF);

    // Partial write of byte 1.
    send(0, 1'b1, 4'b0010, 10'h010, 32'h0000_AA00, 32'h1122_3344);
    send(0, 1'b0, 4'h0, 10'h010, 32'h0, 32'h1122_AA44);

    // Eight back-to-back reads should be accepted in consecutive cycles.
    acc_log.delete();
    for (int i = 0; i < 8; i++) send(0, 1'b0, 4'h0, 10'h020 + 10'(i), 32'h0, 32'hA000_0000 + i);
    for (int i = 1; i < 8 && i < acc_log.size(); i++)
      check($sformatf("b2b cycle[%0d]", i), acc_log[i], acc_log[i-1] + 1);

    // Backpressure on m1 while m0 waits.
    rsp_ready[1] = 1'b0;
    send(1, 1'b0, 4'h0, 10'h3FF, 32'h0, 32'hCAFE_F00D);
    fork
      send(0, 1'b0, 4'h0, 10'h001, 32'h0, 32'h1111_1111);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall m1_rsp_valid[%0d]", i), {31'd0, m1_rsp_valid}, 32'd1);
      check($sformatf("stall m1_rsp_rdata[%0d]", i), m1_rsp_rdata, 32'hCAFE_F00D);
      check($sformatf("stall m0_req_ready[%0d]", i), {31'd0, m0_req_ready}, 32'd0);
      check($sformatf("stall mem_en[%0d]", i), {31'd0, mem_en}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("release m0_req_ready", {31'd0, m0_req_ready}, 32'd1);
    check("release mem_en", {31'd0, mem_en}, 32'd1);
    wait fork;

    // Reset while a response is pending.
    rsp_ready[1] = 1'b0;
    send(1, 1'b0, 4'h0, 10'h002, 32'h0, 32'h2222_2222);
    @(negedge clk);
    check("pre-reset m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd1);
    #1;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 10'h001;
    #1;
    rst = 1'b1;
    #1;
    check("async reset m1_rsp_valid", {31'd0, m1_rsp_valid}, 32'd0);
    check("async reset mem_en", {31'd0, mem_en}, 32'd0);
    check("async reset m0_req_ready", {31'd0, m0_req_ready}, 32'd0);
    sb0.delete();
    sb1.delete();
    started[0] = 1'b0;
    started[1] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    rst          = 1'b0;
    grant_log.delete();
    fork
      send(0, 1'b0, 4'h0, 10'h001, 32'h0, 32'h1111_1111);
      send(1, 1'b0, 4'h0, 10'h002, 32'h0, 32'h2222_2222);
    join
    check("post-reset grant count", grant_log.size(), 2);
    if (grant_log.size() > 0) check("post-reset first grant", grant_log[0], 0);

    repeat (4) @(negedge clk);
    check("sb0 drained", sb0.size(), 0);
    check("sb1 drained", sb1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between two requesters: m0 is the core data port and m1 is the loader/debug port.
- Uses a valid/ready request channel per requester and a valid/ready response channel per requester.
- Round-robin arbitration; one access issued per cycle when responses are consumed promptly.
- Sits between the requesters and the BRAM port (en/we/wstrb/addr/din/dout). Works with the BRAM's 1-cycle registered, read-first dout.

Parameters:
ADDR_WIDTH, 10, word address width (matches BRAM)
DATA_WIDTH, 32, data width; multiple of 8

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mN_req_valid  in  1  request valid (N=0,1; all mN_ ports duplicated per requester)
mN_req_ready  out  1  request accepted when valid&&ready
mN_req_we  in  1  1=write, 0=read
mN_req_wstrb  in  DATA_WIDTH/8  byte enables (writes)
mN_req_addr  in  ADDR_WIDTH  word address
mN_req_wdata  in  DATA_WIDTH  write data
mN_rsp_valid  out  1  response valid
mN_rsp_ready  in  1  response consumed when valid&&ready
mN_rsp_rdata  out  DATA_WIDTH  read data (pre-write contents for writes)
mem_en  out  1  BRAM port enable
mem_we  out  1  BRAM write enable
mem_wstrb  out  DATA_WIDTH/8  BRAM byte strobes
mem_addr  out  ADDR_WIDTH  BRAM address
mem_din  out  DATA_WIDTH  BRAM write data
mem_dout  in  DATA_WIDTH  BRAM read data, valid the cycle after mem_en

Behaviour:
- Registered state: st ∈ {IDLE, BUSY}, owner (1 bit), last_grant (1 bit).
- Reset (async, while rst=1): st=IDLE, owner=0, last_grant=1. Outputs: mN_req_ready=0, mN_rsp_valid=0, mem_en=0.
- Any outstanding response is discarded on reset; BRAM contents are untouched.
- rsp_done = st==BUSY && m[owner]_rsp_ready.
- can_issue = st==IDLE || rsp_done.
- Grant (combinational):
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: no grant.
- mN_req_ready = can_issue && grant==N. Ready may depend on valid; valid must not depend on ready.
- Requesters hold valid and payload stable until accepted.
- Issue, on the cycle a request is accepted:
  - mem_en=1.
  - mem_we/wstrb/addr/din driven combinationally from the granted requester.
- Issue, otherwise: mem_en=0, mem_we=0, mem_wstrb=0. addr/din don't-care.
- mem_we = req_we; mem_wstrb = req_wstrb when writing, 0 when reading.
- On acceptance edge: owner<=grant, last_grant<=grant, st<=BUSY.
- If no acceptance and rsp_done: st<=IDLE.
- Response: mN_rsp_valid = st==BUSY && owner==N. Both mN_rsp_rdata = mem_dout, with no added register.
- Latency: response valid exactly 1 cycle after acceptance.
- Stall: while the response is unconsumed, mem_en stays 0, so dout holds and rdata stays stable indefinitely.
- Throughput: 1 access/cycle when rsp_ready=1. The new issue shares the cycle in which the previous response is consumed.
- Writes also produce a response (write ack). Its rdata is the word's old value.
- Read-after-write to the same address in back-to-back cycles returns the new data.
- Fairness: with both requesters continuously valid and responses consumed immediately, grants alternate strictly 0,1,0,1…
- The first simultaneous contention after reset grants m0.
- A response to owner X never blocks acceptance from the other requester beyond the stall (can_issue rule above).
- The non-owner's rsp_valid is always 0.

Test Plan:
- Write+read m0: write addr 0x005, data 0xDEADBEEF, wstrb 0xF, then read 0x005 → m0_rsp_valid 1 cycle after each accept; read rdata 0xDEADBEEF; write-ack rdata = prior value.
- Partial write: word 0x11223344, write wstrb 0b0010 with data 0x0000AA00, read → 0x1122AA44.
- Contention: m0 and m1 both continuously reading addrs 1 and 2, rsp_ready=1 → grants m0,m1,m0,m1; one mem_en per cycle; m0 always sees word1, m1 always sees word2.
- Backpressure: m1 reads 0x3FF (0xCAFEF00D), m1_rsp_ready low 5 cycles with m0_req_valid high → m1_rsp_valid stays 1, rdata stays 0xCAFEF00D, m0_req_ready=0 and mem_en=0 throughout; m0 accepted in the cycle rsp_ready rises.
- Back-to-back: m0 issues 8 reads at consecutive addresses, rsp_ready=1 → 8 responses in 8 consecutive cycles, in order, correct data.
- Reset mid-op: assert rst while st=BUSY with rsp unconsumed → rsp_valid and mem_en drop immediately (async). After release, m0 and m1 both valid → m0 granted first.
